// File: rtl/imem_dump_unit.sv
// imem_dump_unit: reads a word range from a sync-read memory and streams it MSB-first as bytes; DUMP_CHECKSUM_EN appends an XOR checksum byte
module imem_dump_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam logic [7:0] LAST_IDX = 8'(BPW - 1);
  localparam logic [ADDR_WIDTH:0] MAX_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_CNT = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd5;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [2:0] S_CSUM   = 3'd4;
  logic [7:0] csum_q, csum_d;
`endif
  logic [2:0]            state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, tx_valid_q, tx_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   left_q, left_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_nx;
  logic [7:0]            idx_q, idx_d, tx_data_q, tx_data_d;
  logic                  hs;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign hs        = tx_valid_q && tx_ready;
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    addr_d     = addr_q;
    left_d     = left_q;
    shift_d    = shift_q;
    shift_nx   = shift_q << 8;
    idx_d      = idx_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
`ifdef DUMP_CHECKSUM_EN
        csum_d = 8'h00;
`endif
        if (word_count != '0) begin
          state_d = S_READ;
          rd_en_d = 1'b1;
          addr_d  = base_addr;
          left_d  = (word_count > MAX_CNT) ? MAX_CNT : word_count;
        end else begin
`ifdef DUMP_CHECKSUM_EN
          state_d    = S_CSUM;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h00;
`else
          state_d = S_FINISH;
          done_d  = 1'b1;
`endif
        end
      end
      S_READ: state_d = S_LATCH;
      S_LATCH: begin
        state_d    = S_SEND;
        shift_d    = mem_rd_data;
        tx_data_d  = mem_rd_data[DATA_WIDTH-1 -: 8];
        tx_valid_d = 1'b1;
        idx_d      = 8'd0;
      end
      S_SEND: if (hs) begin
`ifdef DUMP_CHECKSUM_EN
        csum_d = csum_q ^ tx_data_q;
`endif
        if (idx_q != LAST_IDX) begin
          idx_d     = idx_q + 8'd1;
          shift_d   = shift_nx;
          tx_data_d = shift_nx[DATA_WIDTH-1 -: 8];
        end else begin
          tx_valid_d = 1'b0;
          left_d     = left_q - ONE_CNT;
          if (left_q > ONE_CNT) begin
            state_d = S_READ;
            rd_en_d = 1'b1;
            addr_d  = addr_q + 1'b1;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            state_d    = S_CSUM;
            tx_valid_d = 1'b1;
            tx_data_d  = csum_q ^ tx_data_q;
`else
            state_d = S_FINISH;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: if (hs) begin
        state_d    = S_FINISH;
        tx_valid_d = 1'b0;
        done_d     = 1'b1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      addr_q     <= '0;
      left_q     <= '0;
      shift_q    <= '0;
      idx_q      <= 8'd0;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_imem_dump_unit.sv
// tb_imem_dump_unit: scoreboard bench for imem_dump_unit; honours DUMP_CHECKSUM_EN
module tb_imem_dump_unit;
  localparam int AW = 8;
  localparam int DW = 32;
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, tx_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done, mem_rd_en, tx_valid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    tx_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] mem [256];
  int            n_cmp = 0, n_bad = 0, done_cnt = 0, rd_cnt = 0, hs_cnt = 0;
  logic [7:0]    exp_q [$];
  logic [AW-1:0] addr_q [$];
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
  logic [7:0]    prev_d = 8'h00;

  imem_dump_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // monitor: scoreboard pops on handshake, backpressure stability, strobe logging
  always @(negedge clk) begin
    if (!prev_rst && prev_v && !prev_r) begin
      check("hold_valid", 32'(tx_valid), 1);
      check("hold_data", 32'(tx_data), 32'(prev_d));
    end
    if (tx_valid && tx_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) check("byte_expected", 32'(exp_q.size()), 1);
      else check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    if (done) done_cnt++;
    if (mem_rd_en) begin
      rd_cnt++;
      addr_q.push_back(mem_addr);
    end
    prev_v   = tx_valid;
    prev_r   = tx_ready;
    prev_d   = tx_data;
    prev_rst = rst;
  end

  task automatic push_words(input logic [AW-1:0] b, input int n);
    logic [7:0]    cs;
    logic [DW-1:0] w;
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = mem[8'(int'(b) + i)];
      for (int k = DW / 8 - 1; k >= 0; k--) begin
        exp_q.push_back(w[k*8 +: 8]);
        cs ^= w[k*8 +: 8];
      end
    end
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] c);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_dump(input int max, input bit rnd);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(posedge clk); #1;
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      seen = done;
    end
    check("done_seen", 32'(seen), 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("busy_after", 32'(busy), 0);
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, r0, h0;
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0]   = 32'h20080005;
    mem[1]   = 32'h2009000A;
    mem[255] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_data", 32'(tx_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_ready = 1'b1;

    // basic dump with latency probes around the sampling edge
    push_words(8'd0, 2);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'd0; word_count = 9'd2;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    check("e0_busy", 32'(busy), 1);
    check("e0_rd_en", 32'(mem_rd_en), 1);
    check("e0_addr", 32'(mem_addr), 0);
    check("e0_valid", 32'(tx_valid), 0);
    @(negedge clk);
    check("e1_valid", 32'(tx_valid), 0);
    check("e1_rd_en", 32'(mem_rd_en), 0);
    @(negedge clk);
    check("e2_valid", 32'(tx_valid), 1);
    check("e2_data", 32'(tx_data), 'h20);
    finish_dump(50, 1'b0);

    // backpressure on byte 0x08
    push_words(8'd0, 2);
    pulse_start(8'd0, 9'd2);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      found = tx_valid && tx_data == 8'h08;
    end
    check("saw_08", 32'(found), 1);
    tx_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(tx_valid), 1);
      check("bp_data", 32'(tx_data), 'h08);
    end
    tx_ready = 1'b1;
    finish_dump(50, 1'b0);

    // zero count
    d0 = done_cnt;
    r0 = rd_cnt;
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(8'h00);
`endif
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'd7; word_count = 9'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_rd_en", 32'(mem_rd_en), 0);
`ifdef DUMP_CHECKSUM_EN
    check("zero_csum_valid", 32'(tx_valid), 1);
    check("zero_csum_data", 32'(tx_data), 0);
    check("zero_done_early", 32'(done), 0);
`else
    check("zero_done", 32'(done), 1);
    check("zero_valid", 32'(tx_valid), 0);
`endif
    repeat (4) @(negedge clk);
    check("zero_done_cnt", done_cnt - d0, 1);
    check("zero_reads", rd_cnt - r0, 0);
    check("zero_busy", 32'(busy), 0);
    check("zero_queue", exp_q.size(), 0);

    // address wrap with random backpressure
    addr_q.delete();
    push_words(8'd255, 2);
    pulse_start(8'd255, 9'd2);
    finish_dump(80, 1'b1);
    check("wrap_reads", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      check("wrap_addr0", 32'(addr_q[0]), 255);
      check("wrap_addr1", 32'(addr_q[1]), 0);
    end

    // oversize count clamps to the full address space
    r0 = rd_cnt;
    push_words(8'h10, 256);
    pulse_start(8'h10, 9'h1FF);
    finish_dump(3000, 1'b0);
    check("clamp_reads", rd_cnt - r0, 256);

    // ignored start mid-dump, then reset after the third byte
    push_words(8'd4, 4);
    h0 = hs_cnt;
    d0 = done_cnt;
    pulse_start(8'd4, 9'd4);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 8'h80; word_count = 9'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40 && (hs_cnt - h0) < 3; i++) begin
      @(posedge clk); #1;
    end
    check("rst_bytes_sent", hs_cnt - h0, 3);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", 32'(busy), 0);
    check("mid_valid", 32'(tx_valid), 0);
    check("mid_done", 32'(done), 0);
    check("mid_rd_en", 32'(mem_rd_en), 0);
    check("mid_data", 32'(tx_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("mid_no_done", done_cnt - d0, 0);
    push_words(8'h40, 1);
    pulse_start(8'h40, 9'd1);
    finish_dump(40, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
